// File: rtl/sparc_ifu_thrsched_pkg.sv
// Shared constants for the IFU thread scheduler: thread FSM encodings,
// thread count, quantum defaults and scheduler state encodings.
package sparc_ifu_thrsched_pkg;

  localparam int NTHR    = 4;
  localparam int QWIDTH  = 4;
  localparam int QUANTUM = 15;

  localparam logic [4:0] THRFSM_RDY      = 5'b11001;
  localparam logic [4:0] THRFSM_RUN      = 5'b00101;
  localparam logic [4:0] THRFSM_SPEC_RDY = 5'b10011;
  localparam logic [4:0] THRFSM_SPEC_RUN = 5'b00111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_SWITCH = 2'b10
  } sched_st_e;

  // One bit per thread: thread t's 5-bit state equals code.
  function automatic logic [NTHR-1:0] st_match(
    input logic [5*NTHR-1:0] st,
    input logic [4:0]        code
  );
    logic [NTHR-1:0] m;
    m = '0;
    for (int t = 0; t < NTHR; t++)
      m[t] = (st[5*t +: 5] == code);
    return m;
  endfunction

endpackage

// File: rtl/sparc_ifu_rrarb4.sv
// Combinational 4-way round-robin picker.
// Ports: req_i (requests), ptr_i (one-hot last grant, lowest priority),
// grant_o (one-hot grant, 0 when no request).
module sparc_ifu_rrarb4 (
  input  logic [3:0] req_i,
  input  logic [3:0] ptr_i,
  output logic [3:0] grant_o
);

  logic [1:0] last;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    last = 2'd3;
    for (int i = 0; i < 4; i++)
      if (ptr_i[i]) last = 2'(i);
  end

  // Walk from last+1 around to last itself.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// IFU thread scheduler: round-robin pick of ready threads with quantum.
// Ports: clk_i, rst_l_i (sync low), thr_state_i, sw_req_i, sched_hold_i,
// schedule_o, switch_out_o, cur_thr_o, cur_vld_o. Macro: SPARC_IFU_SPEC_SCHED_EN.
module sparc_ifu_thrsched
  import sparc_ifu_thrsched_pkg::*;
#(
  parameter int QW   = QWIDTH,
  parameter int QMAX = QUANTUM
) (
  input  logic              clk_i,
  input  logic              rst_l_i,
  input  logic [5*NTHR-1:0] thr_state_i,
  input  logic              sw_req_i,
  input  logic              sched_hold_i,
  output logic [NTHR-1:0]   schedule_o,
  output logic [NTHR-1:0]   switch_out_o,
  output logic [NTHR-1:0]   cur_thr_o,
  output logic              cur_vld_o
);

  localparam logic [QW-1:0] QLIM = QW'(QMAX);

  sched_st_e       st_q, st_d;
  logic [NTHR-1:0] sched_q, sched_d;
  logic [NTHR-1:0] swo_q, swo_d;
  logic [NTHR-1:0] cur_q, cur_d;
  logic            vld_q, vld_d;
  logic [QW-1:0]   cnt_q, cnt_d;
  logic [NTHR-1:0] ptr_q, ptr_d;

  logic [NTHR-1:0] rdy, run, elig, q_elig, grant;
  logic            cur_run, grace;

  assign rdy = st_match(thr_state_i, THRFSM_RDY);
  assign run = st_match(thr_state_i, THRFSM_RUN)
             | st_match(thr_state_i, THRFSM_SPEC_RUN);

`ifdef SPARC_IFU_SPEC_SCHED_EN
  logic [NTHR-1:0] srdy;
  assign srdy   = st_match(thr_state_i, THRFSM_SPEC_RDY);
  assign elig   = (|rdy) ? rdy : srdy;
  assign q_elig = (rdy | srdy) & ~cur_q;
`else
  assign elig   = rdy;
  assign q_elig = rdy & ~cur_q;
`endif

  // The switched-in thread may still show RDY while its schedule pulse is out.
  assign grace   = |sched_q;
  assign cur_run = |(run & cur_q);

  sparc_ifu_rrarb4 u_arb (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    st_d    = st_q;
    sched_d = '0;
    swo_d   = '0;
    cur_d   = cur_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (st_q)
      S_IDLE: begin
        if (!sched_hold_i && |elig) begin
          sched_d = grant;
          cur_d   = grant;
          vld_d   = 1'b1;
          cnt_d   = '0;
          ptr_d   = grant;
          st_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != QLIM) cnt_d = cnt_q + QW'(1);
        if (!cur_run && !grace) begin
          cur_d = '0;
          vld_d = 1'b0;
          st_d  = S_IDLE;
        end else if (sw_req_i || (cnt_q == QLIM && |q_elig)) begin
          swo_d = cur_q;
          cur_d = '0;
          vld_d = 1'b0;
          st_d  = S_SWITCH;
        end
      end
      S_SWITCH: st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_l_i) begin
      st_q    <= S_IDLE;
      sched_q <= '0;
      swo_q   <= '0;
      cur_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 4'b1000;
    end else begin
      st_q    <= st_d;
      sched_q <= sched_d;
      swo_q   <= swo_d;
      cur_q   <= cur_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign schedule_o   = sched_q;
  assign switch_out_o = swo_q;
  assign cur_thr_o    = cur_q;
  assign cur_vld_o    = vld_q;

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Directed bench for sparc_ifu_thrsched.
// Drives thread states and sw_req/hold; checks pulses and cur_thr.
module tb_sparc_ifu_thrsched;
  import sparc_ifu_thrsched_pkg::*;

  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] WAIT = 5'b00010;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [19:0] thr_state;
  logic        sw_req;
  logic        sched_hold;
  logic [3:0]  schedule;
  logic [3:0]  switch_out;
  logic [3:0]  cur_thr;
  logic        cur_vld;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_ord [5];

  always #5 clk = ~clk;

  sparc_ifu_thrsched dut (
    .clk_i        (clk),
    .rst_l_i      (rst_l),
    .thr_state_i  (thr_state),
    .sw_req_i     (sw_req),
    .sched_hold_i (sched_hold),
    .schedule_o   (schedule),
    .switch_out_o (switch_out),
    .cur_thr_o    (cur_thr),
    .cur_vld_o    (cur_vld)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input int t, input logic [4:0] s);
    thr_state[5*t +: 5] = s;
  endtask

  task automatic do_reset();
    rst_l      = 1'b0;
    sw_req     = 1'b0;
    sched_hold = 1'b0;
    thr_state  = '0;
    tick();
    tick();
    rst_l = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] sc,
                         input logic [3:0] so, input logic [3:0] cu);
    chk({tag, ".sched"}, 32'(schedule), 32'(sc));
    chk({tag, ".swo"}, 32'(switch_out), 32'(so));
    chk({tag, ".cur"}, 32'(cur_thr), 32'(cu));
    chk({tag, ".vld"}, 32'(cur_vld), 32'(|cu));
  endtask

  initial begin
    rst_l      = 1'b0;
    sw_req     = 1'b0;
    sched_hold = 1'b0;
    thr_state  = '0;

    // reset state
    do_reset();
    chk_out("rst", 4'b0000, 4'b0000, 4'b0000);

    // T0 alone: scheduled, never switched by quantum
    set_thr(0, THRFSM_RDY);
    tick();
    chk_out("t1.sch", 4'b0001, 4'b0000, 4'b0001);
    set_thr(0, THRFSM_RUN);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out("t1.run", 4'b0000, 4'b0000, 4'b0001);
    end

    // quantum expiry with T2 waiting
    do_reset();
    set_thr(0, THRFSM_RDY);
    tick();
    chk_out("t2.sch", 4'b0001, 4'b0000, 4'b0001);
    set_thr(0, THRFSM_RUN);
    set_thr(2, THRFSM_RDY);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t2.noswo", 32'(switch_out), 32'h0);
    end
    tick();
    chk_out("t2.swo", 4'b0000, 4'b0001, 4'b0000);
    tick();
    chk_out("t2.bub", 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk_out("t2.sch2", 4'b0100, 4'b0000, 4'b0100);

    // leaving RUN beats sw_req
    do_reset();
    set_thr(1, THRFSM_RDY);
    tick();
    chk_out("t3.sch", 4'b0010, 4'b0000, 4'b0010);
    set_thr(1, THRFSM_RUN);
    tick();
    chk_out("t3.run", 4'b0000, 4'b0000, 4'b0010);
    sw_req = 1'b1;
    set_thr(1, WAIT);
    tick();
    chk_out("t3.stall", 4'b0000, 4'b0000, 4'b0000);
    sw_req = 1'b0;
    tick();
    chk_out("t3.idle", 4'b0000, 4'b0000, 4'b0000);
    set_thr(3, THRFSM_RDY);
    tick();
    chk_out("t3.resch", 4'b1000, 4'b0000, 4'b1000);

    // round-robin order with sw_req
    do_reset();
    exp_ord[0] = 4'b0001;
    exp_ord[1] = 4'b0010;
    exp_ord[2] = 4'b0100;
    exp_ord[3] = 4'b1000;
    exp_ord[4] = 4'b0001;
    for (int t = 0; t < 4; t++) set_thr(t, THRFSM_RDY);
    tick();
    chk_out("rr.sch0", exp_ord[0], 4'b0000, exp_ord[0]);
    for (int k = 1; k < 5; k++) begin
      set_thr((k - 1) % 4, THRFSM_RUN);
      tick();
      sw_req = 1'b1;
      tick();
      chk_out("rr.swo", 4'b0000, exp_ord[k-1], 4'b0000);
      sw_req = 1'b0;
      set_thr((k - 1) % 4, THRFSM_RDY);
      tick();
      chk("rr.bub", 32'(schedule), 32'h0);
      tick();
      chk_out("rr.sch", exp_ord[k], 4'b0000, exp_ord[k]);
    end

    // sched_hold blocks scheduling
    do_reset();
    sched_hold = 1'b1;
    set_thr(3, THRFSM_RDY);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("hold", 4'b0000, 4'b0000, 4'b0000);
    end
    sched_hold = 1'b0;
    tick();
    chk_out("hold.rel", 4'b1000, 4'b0000, 4'b1000);

    // reset during S_SWITCH
    set_thr(3, THRFSM_RUN);
    tick();
    sw_req = 1'b1;
    tick();
    chk_out("rsw.swo", 4'b0000, 4'b1000, 4'b0000);
    sw_req = 1'b0;
    rst_l  = 1'b0;
    thr_state = '0;
    tick();
    chk_out("rsw.rst", 4'b0000, 4'b0000, 4'b0000);
    rst_l = 1'b1;
    tick();
    chk_out("rsw.after", 4'b0000, 4'b0000, 4'b0000);

    // SPEC_RDY with a RDY thread: RDY wins
    do_reset();
    set_thr(1, THRFSM_SPEC_RDY);
    set_thr(2, THRFSM_RDY);
    tick();
    chk_out("spec.mix", 4'b0100, 4'b0000, 4'b0100);

    // SPEC_RDY alone
    do_reset();
    set_thr(1, THRFSM_SPEC_RDY);
    tick();
`ifdef SPARC_IFU_SPEC_SCHED_EN
    chk_out("spec.only", 4'b0010, 4'b0000, 4'b0010);
`else
    chk_out("spec.only", 4'b0000, 4'b0000, 4'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
